sl_receiver: RTL and testbench

Receive side of the two-wire SL serial link, the counterpart of the SL transmitter. Decodes return-to-idle pulses on SL0/SL1 into 8..32-bit words with a trailing odd-parity bit and stop symbol. Presents received data, configuration and status through the same 32-bit single-address-bit register port the transmitter uses, plus an interrupt line.

---
 rtl/sl_receiver.sv | 204 ++++++++++++++++++++
 tb/tb_sl_receiver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sl_receiver.sv
// Receive side of the two-wire SL serial link: decodes return-to-idle pulses on
// SL0/SL1 into parity-checked words and exposes data/config/status registers.
module sl_receiver #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SL0,
  input  logic        SL1,
  input  logic [31:0] d_in,
  input  logic        addr,
  input  logic        wr_en,
  output logic [31:0] d_out,
  output logic        irq
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CFG_W   = 16;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned TMR_W   = 8;
  localparam int unsigned ST_W    = 5;
  localparam logic [CFG_W-1:0] CFG_RST = 16'h0210;

  typedef enum logic [2:0] {S_IDLE, S_BIT, S_GAP, S_STOP, S_HUNT} state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync0_q, sync0_d, sync1_q, sync1_d;
  logic [1:0]               pair_q, pair_d;
  logic [DATA_W:0]          data_q, data_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [TMR_W-1:0]         tmr_q, tmr_d;
  logic [DATA_W-1:0]        rx_q, rx_d;
  logic [CFG_W-1:0]         cfg_q, cfg_d;
  logic [ST_W-1:0]          st_q, st_d;
  logic                     irq_q, irq_d;

  logic [1:0]       pair;
  logic             changed, is_pulse, bit_val, timeout;
  logic [5:0]       bq, wr_len;
  logic [2:0]       fq, fq_eff;
  logic [TMR_W-1:0] t_val, four_t;
  logic [DATA_W:0]  mask_full;
  logic [DATA_W-1:0] masked;
  logic             set_fe, set_pe, set_rm, set_ic, cfg_wr, len_ok;
  logic [ST_W-1:0]  st_set, st_clr;
  logic             unused_d_in;

  assign unused_d_in = ^d_in[31:16];

  // Line synchronizers; stage 0 samples the asynchronous pins
  always_comb begin
    sync0_d = {sync0_q[SYNC_STAGES-2:0], SL0};
    sync1_d = {sync1_q[SYNC_STAGES-2:0], SL1};
  end

  assign pair     = {sync1_q[SYNC_STAGES-1], sync0_q[SYNC_STAGES-1]};
  assign changed  = (pair != pair_q);
  assign is_pulse = (pair == 2'b10) || (pair == 2'b01);
  assign bit_val  = (pair == 2'b01);

  assign bq     = cfg_q[6:1];
  assign fq     = cfg_q[10:8];
  assign fq_eff = (fq > 3'd4) ? 3'd0 : fq;
  assign t_val  = TMR_W'(2) << fq_eff;
  assign four_t = t_val << 2;

  assign timeout   = !changed && (tmr_q >= four_t - TMR_W'(1));
  assign mask_full = (33'(1) << bq) - 33'(1);
  assign masked    = data_q[DATA_W-1:0] & mask_full[DATA_W-1:0];

  // Cycles since the synchronized pair last changed; parked at 0 in IDLE
  always_comb begin
    pair_d = pair;
    tmr_d  = tmr_q;
    if (state_q == S_IDLE || changed) begin
      tmr_d = '0;
    end else if (tmr_q != {TMR_W{1'b1}}) begin
      tmr_d = tmr_q + TMR_W'(1);
    end
  end

  // Symbol decoder FSM
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    set_fe  = 1'b0;
    set_pe  = 1'b0;
    set_rm  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_q[0]) begin
          if (is_pulse) begin
            data_d  = 33'(bit_val);
            cnt_d   = CNT_W'(1);
            state_d = S_BIT;
          end else if (pair == 2'b00) begin
            state_d = S_HUNT;
          end
        end
      end
      S_BIT: begin
        if (timeout || pair == 2'b00 || (is_pulse && changed)) begin
          set_fe  = 1'b1;
          state_d = S_HUNT;
        end else if (pair == 2'b11) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (timeout) begin
          set_fe  = 1'b1;
          state_d = S_HUNT;
        end else if (is_pulse) begin
          if (cnt_q > CNT_W'(DATA_W)) begin
            set_fe  = 1'b1;
            state_d = S_HUNT;
          end else begin
            data_d[cnt_q] = bit_val;
            cnt_d         = cnt_q + CNT_W'(1);
            state_d       = S_BIT;
          end
        end else if (pair == 2'b00) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timeout || is_pulse) begin
          set_fe  = 1'b1;
          state_d = S_HUNT;
        end else if (pair == 2'b11) begin
          state_d = S_IDLE;
          if (7'(cnt_q) != 7'(bq) + 7'd1) begin
            set_fe = 1'b1;
          end else if (!(^masked ^ data_q[bq])) begin
            set_pe = 1'b1;
          end else begin
            rx_d   = masked;
            set_rm = 1'b1;
          end
        end
      end
      S_HUNT: begin
        if (pair == 2'b11 && !changed && tmr_q >= t_val - TMR_W'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Config write, sticky status with write-zero-to-clear, interrupt
  always_comb begin
    cfg_wr = wr_en && addr;
    wr_len = d_in[6:1];
    len_ok = (wr_len >= 6'd8) && (wr_len <= 6'd32) && !d_in[1];
    cfg_d  = cfg_q;
    set_ic = 1'b0;
    if (cfg_wr) begin
      if (len_ok && state_q == S_IDLE) begin
        cfg_d = d_in[15:0];
      end else begin
        set_ic = 1'b1;
      end
    end
    st_set = {set_rm && st_q[0], set_fe, set_ic, set_pe, set_rm};
    st_clr = cfg_wr ? ~d_in[12:8] : '0;
    st_d   = (st_q & ~st_clr) | st_set;
    irq_d  = cfg_q[7] && (|st_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync0_q <= '1;
      sync1_q <= '1;
      pair_q  <= 2'b11;
      data_q  <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      rx_q    <= '0;
      cfg_q   <= CFG_RST;
      st_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      pair_q  <= pair_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      rx_q    <= rx_d;
      cfg_q   <= cfg_d;
      st_q    <= st_d;
      irq_q   <= irq_d;
    end
  end

  assign d_out = addr ? {3'b000, st_q, 7'b0000000, (state_q != S_IDLE), cfg_q} : rx_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_sl_receiver.sv
// Directed bench for sl_receiver: drives SL symbol sequences, predicts register
// contents with a small model and checks them through a scoreboard queue.
module tb_sl_receiver;

  localparam int HOLD = 3;

  logic        clk = 1'b0;
  logic        rst_n, SL0, SL1, wr_en, addr, irq;
  logic [31:0] d_in, d_out;

  typedef struct packed {
    logic [31:0] rx;
    logic [4:0]  st;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_rx;
  logic [4:0]  exp_st;   // {OV, FE, IC, PE, RM}
  logic [15:0] exp_cfg;
  logic [31:0] v;

  always #5 clk = ~clk;

  sl_receiver #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .SL0   (SL0),
    .SL1   (SL1),
    .d_in  (d_in),
    .addr  (addr),
    .wr_en (wr_en),
    .d_out (d_out),
    .irq   (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic a, output logic [31:0] val);
    addr = a;
    #1;
    val = d_out;
  endtask

  function automatic logic [31:0] cfgv(input int bq, input bit irqm);
    return (32'(bq) << 1) | (32'(irqm) << 7) | 32'd1;
  endfunction

  task automatic model_write(input logic [31:0] val, input bit busy);
    bit ok;
    ok = (val[6:1] >= 6'd8) && (val[6:1] <= 6'd32) && !val[1] && !busy;
    exp_st = exp_st & val[12:8];
    if (ok) exp_cfg = val[15:0];
    else    exp_st[2] = 1'b1;
  endtask

  task automatic cfg_write(input logic [31:0] val);
    model_write(val, 1'b0);
    addr = 1'b1; d_in = val; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drive_sym(input logic s1, input logic s0, input int n);
    SL1 = s1; SL0 = s0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] r;
    rd(1'b1, r);
    check({tag, "_status"}, {16'h0, r[31:16]}, {19'h0, exp_st, 8'h00});
    check({tag, "_config"}, {16'h0, r[15:0]}, {16'h0, exp_cfg});
  endtask

  // Sends ndata bits LSB first plus parity (optionally corrupted); may pulse a
  // config write at the start of symbol wr_at. Pushes the predicted outcome.
  task automatic send_word(input logic [31:0] data, input int ndata, input bit par_ok,
                           input int wr_at, input logic [31:0] wr_val);
    logic [31:0] dm;
    logic [33:0] bits;
    logic        p;
    int          nb;
    dm = '0;
    for (int i = 0; i < ndata; i++) dm[i] = data[i];
    p = ~(^dm);
    if (!par_ok) p = ~p;
    bits = 34'(dm);
    bits[ndata] = p;
    nb = ndata + 1;
    if (wr_at >= 0 && wr_at < nb) model_write(wr_val, 1'b1);
    if (nb != int'(exp_cfg[6:1]) + 1) exp_st[3] = 1'b1;
    else if (!par_ok) exp_st[1] = 1'b1;
    else begin
      exp_rx = dm;
      if (exp_st[0]) exp_st[4] = 1'b1;
      exp_st[0] = 1'b1;
    end
    sb.push_back('{rx: exp_rx, st: exp_st});
    for (int i = 0; i < nb; i++) begin
      if (i == wr_at) begin
        addr = 1'b1; d_in = wr_val; wr_en = 1'b1;
      end
      if (bits[i]) drive_sym(1'b0, 1'b1, 1);
      else         drive_sym(1'b1, 1'b0, 1);
      wr_en = 1'b0;
      repeat (HOLD - 1) @(negedge clk);
      drive_sym(1'b1, 1'b1, HOLD);
    end
    drive_sym(1'b0, 1'b0, HOLD);
    drive_sym(1'b1, 1'b1, HOLD);
  endtask

  // Waits (bounded) for the receiver to go idle, then pops and compares
  task automatic expect_word(input string tag);
    logic [31:0] r;
    exp_t        e;
    int          n;
    n = 0;
    @(negedge clk);
    rd(1'b1, r);
    while (r[16] && n < 200) begin
      @(negedge clk);
      rd(1'b1, r);
      n++;
    end
    check({tag, "_rip"}, {31'h0, r[16]}, 32'h0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      check({tag, "_status"}, {16'h0, r[31:16]}, {19'h0, e.st, 8'h00});
      rd(1'b0, r);
      check({tag, "_rxdata"}, r, e.rx);
      check({tag, "_irq"}, {31'h0, irq}, {31'h0, exp_cfg[7] & (|e.st)});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; SL0 = 1'b1; SL1 = 1'b1; wr_en = 1'b0; addr = 1'b0; d_in = '0;
    exp_rx = '0; exp_st = '0; exp_cfg = 16'h0210;
    repeat (3) @(negedge clk);
    rd(1'b0, v); check("reset_rxdata", v, 32'h0);
    rd(1'b1, v); check("reset_regs", v, 32'h0000_0210);
    check("reset_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic receive, IRQM off
    cfg_write(cfgv(8, 0));
    check_regs("cfg8");
    send_word(32'hA5, 8, 1'b1, -1, '0);
    expect_word("a5");

    // IRQM on, then clear RM by writing 0 to bit 8
    cfg_write(cfgv(8, 1));
    send_word(32'hFF, 8, 1'b1, -1, '0);
    expect_word("ff_irq");
    cfg_write(cfgv(8, 1));
    check_regs("rm_clr");
    @(negedge clk);
    check("rm_clr_irq", {31'h0, irq}, 32'h0);

    // 32-bit word with bad parity
    cfg_write(cfgv(32, 0));
    send_word(32'hDEAD_BEEF, 32, 1'b0, -1, '0);
    expect_word("pe32");

    // Short word at BQ=16
    cfg_write(cfgv(16, 0));
    send_word(32'h2B5, 10, 1'b1, -1, '0);
    expect_word("short");

    // Line stuck low mid-word
    cfg_write(cfgv(16, 0));
    drive_sym(1'b0, 1'b1, HOLD);
    drive_sym(1'b1, 1'b1, HOLD);
    drive_sym(1'b1, 1'b0, 20);
    rd(1'b1, v);
    check("stuck_rip", {31'h0, v[16]}, 32'h1);
    exp_st[3] = 1'b1;
    sb.push_back('{rx: exp_rx, st: exp_st});
    drive_sym(1'b1, 1'b1, HOLD);
    expect_word("stuck");

    // Overrun on back-to-back words
    cfg_write(cfgv(8, 0));
    send_word(32'h3C, 8, 1'b1, -1, '0);
    expect_word("ov_first");
    send_word(32'h81, 8, 1'b1, -1, '0);
    expect_word("ov_second");

    // Illegal config lengths and write while busy
    cfg_write((32'd7 << 1) | 32'd1);
    check_regs("ic_len7");
    cfg_write((32'd34 << 1) | 32'd1);
    check_regs("ic_len34");
    cfg_write(cfgv(8, 0));
    send_word(32'h5A, 8, 1'b1, 3, cfgv(16, 0));
    expect_word("ic_busy");
    check_regs("ic_busy_regs");

    // Reset in the middle of a word, then a clean word
    drive_sym(1'b1, 1'b0, HOLD);
    drive_sym(1'b1, 1'b1, HOLD);
    drive_sym(1'b0, 1'b1, 1);
    rst_n = 1'b0;
    exp_rx = '0; exp_st = '0; exp_cfg = 16'h0210;
    rd(1'b0, v); check("midrst_rxdata", v, 32'h0);
    rd(1'b1, v); check("midrst_regs", v, 32'h0000_0210);
    SL0 = 1'b1; SL1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cfg_write(cfgv(8, 0));
    send_word(32'h11, 8, 1'b1, -1, '0);
    expect_word("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
